// File: rtl/jk_bank_controller.sv
// Command sequencer driving a bank of JK flip-flops: load/set/clear/toggle,
// multi-step up/down counting and left rotation via per-cycle J/K drive.

module jk_cell (
    input  logic clk,
    input  logic rst,
    input  logic j,
    input  logic k,
    output logic q
);
    logic q_q;
    logic q_d;

    always_comb begin
        q_d = (j & ~q_q) | (~k & q_q);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) q_q <= 1'b0;
        else     q_q <= q_d;
    end

    assign q = q_q;
endmodule

module jk_bank_controller #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_arg,
    input  logic [3:0]       cmd_count,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] j_out,
    output logic [WIDTH-1:0] k_out,
    output logic             busy,
    output logic             done
);
    localparam int unsigned STEP_W = 4;

    localparam logic [2:0] OP_NOP    = 3'b000;
    localparam logic [2:0] OP_LOAD   = 3'b001;
    localparam logic [2:0] OP_CLEAR  = 3'b010;
    localparam logic [2:0] OP_SET    = 3'b011;
    localparam logic [2:0] OP_TOGGLE = 3'b100;
    localparam logic [2:0] OP_UP     = 3'b101;
    localparam logic [2:0] OP_DOWN   = 3'b110;
    localparam logic [2:0] OP_ROTL   = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [2:0]          op_q, op_d;
    logic [WIDTH-1:0]    arg_q, arg_d;
    logic [STEP_W-1:0]   steps_q, steps_d;

    logic [WIDTH-1:0]    t_up;
    logic [WIDTH-1:0]    t_dn;
    logic [WIDTH-1:0]    rot;
    logic [WIDTH-1:0]    j_c;
    logic [WIDTH-1:0]    k_c;

    // Carry/borrow chains: a bit toggles when all lower bits are 1 (up) or 0 (down)
    always_comb begin
        t_up    = '0;
        t_dn    = '0;
        t_up[0] = 1'b1;
        t_dn[0] = 1'b1;
        for (int i = 1; i < int'(WIDTH); i++) begin
            t_up[i] = t_up[i-1] & q[i-1];
            t_dn[i] = t_dn[i-1] & ~q[i-1];
        end
        rot = {q[WIDTH-2:0], q[WIDTH-1]};
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        arg_d   = arg_q;
        steps_d = steps_q;
        j_c     = '0;
        k_c     = '0;

        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    state_d = EXEC;
                    op_d    = cmd_op;
                    arg_d   = cmd_arg;
                    // Only 101..111 take a step count; everything else is a single step
                    if (cmd_op[2] && (cmd_op[1] || cmd_op[0])) steps_d = cmd_count;
                    else                                       steps_d = STEP_W'(1);
                end
            end
            EXEC: begin
                if (steps_q != '0) begin
                    case (op_q)
                        OP_NOP:    begin j_c = '0;     k_c = '0;     end
                        OP_LOAD:   begin j_c = arg_q;  k_c = ~arg_q; end
                        OP_CLEAR:  begin j_c = '0;     k_c = arg_q;  end
                        OP_SET:    begin j_c = arg_q;  k_c = '0;     end
                        OP_TOGGLE: begin j_c = arg_q;  k_c = arg_q;  end
                        OP_UP:     begin j_c = t_up;   k_c = t_up;   end
                        OP_DOWN:   begin j_c = t_dn;   k_c = t_dn;   end
                        OP_ROTL:   begin j_c = rot;    k_c = ~rot;   end
                        default:   begin j_c = '0;     k_c = '0;     end
                    endcase
                end
                if (steps_q <= STEP_W'(1)) state_d = DONE;
                else                       steps_d = steps_q - STEP_W'(1);
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            op_q    <= '0;
            arg_q   <= '0;
            steps_q <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            arg_q   <= arg_d;
            steps_q <= steps_d;
        end
    end

    for (genvar g = 0; g < int'(WIDTH); g++) begin : g_cell
        jk_cell u_cell (
            .clk (clk),
            .rst (rst),
            .j   (j_c[g]),
            .k   (k_c[g]),
            .q   (q[g])
        );
    end

    assign j_out     = j_c;
    assign k_out     = k_c;
    assign cmd_ready = (state_q == IDLE);
    assign busy      = (state_q == EXEC) || (state_q == DONE);
    assign done      = (state_q == DONE);
endmodule

// File: tb/tb_jk_bank_controller.sv
// Directed bench for jk_bank_controller (WIDTH=4) with hand-computed expectations.

module tb_jk_bank_controller;
    logic       clk;
    logic       rst;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [2:0] cmd_op;
    logic [3:0] cmd_arg;
    logic [3:0] cmd_count;
    logic [3:0] q;
    logic [3:0] j_out;
    logic [3:0] k_out;
    logic       busy;
    logic       done;

    int n_checks = 0;
    int n_fails  = 0;

    jk_bank_controller #(.WIDTH(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_arg   (cmd_arg),
        .cmd_count (cmd_count),
        .q         (q),
        .j_out     (j_out),
        .k_out     (k_out),
        .busy      (busy),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Present a command, wait (bounded) for acceptance, then scramble the inputs
    task automatic send(input logic [2:0] op, input logic [3:0] arg, input logic [3:0] cnt);
        int guard;
        guard = 0;
        @(negedge clk);
        cmd_op    = op;
        cmd_arg   = arg;
        cmd_count = cnt;
        cmd_valid = 1'b1;
        while (!cmd_ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        if (!cmd_ready) check("ready_timeout", 32'(cmd_ready), 32'd1);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        cmd_op    = 3'($urandom);
        cmd_arg   = 4'($urandom);
        cmd_count = 4'($urandom);
    endtask

    // Single-step op: drive after accept, result at E1 with done, ready at E2
    task automatic single(input string tag, input logic [2:0] op, input logic [3:0] arg,
                          input logic [3:0] exp_j, input logic [3:0] exp_k, input logic [3:0] exp_q);
        send(op, arg, 4'd7);
        check({tag, "_j"},     32'(j_out),     32'(exp_j));
        check({tag, "_k"},     32'(k_out),     32'(exp_k));
        check({tag, "_busy0"}, 32'(busy),      32'd1);
        check({tag, "_rdy0"},  32'(cmd_ready), 32'd0);
        @(posedge clk); #1;
        check({tag, "_q"},     32'(q),         32'(exp_q));
        check({tag, "_done"},  32'(done),      32'd1);
        @(posedge clk); #1;
        check({tag, "_done2"}, 32'(done),      32'd0);
        check({tag, "_rdy2"},  32'(cmd_ready), 32'd1);
        check({tag, "_busy2"}, 32'(busy),      32'd0);
    endtask

    initial begin
        int done_seen;
        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_op    = 3'd0;
        cmd_arg   = 4'd0;
        cmd_count = 4'd0;

        #12;
        check("rst_q",     32'(q),         32'h0);
        check("rst_ready", 32'(cmd_ready), 32'd1);
        check("rst_busy",  32'(busy),      32'd0);
        check("rst_done",  32'(done),      32'd0);
        check("rst_j",     32'(j_out),     32'h0);
        check("rst_k",     32'(k_out),     32'h0);
        @(negedge clk);
        rst = 1'b0;

        single("load",   3'b001, 4'b1010, 4'b1010, 4'b0101, 4'b1010);
        single("set",    3'b011, 4'b0101, 4'b0101, 4'b0000, 4'b1111);
        single("clear",  3'b010, 4'b0011, 4'b0000, 4'b0011, 4'b1100);
        single("toggle", 3'b100, 4'b1111, 4'b1111, 4'b1111, 4'b0011);
        single("nop",    3'b000, 4'b1111, 4'b0000, 4'b0000, 4'b0011);

        // Count up 3 from 1110 wraps through 0000
        single("ld_e", 3'b001, 4'b1110, 4'b1110, 4'b0001, 4'b1110);
        send(3'b101, 4'b0000, 4'd3);
        check("up_j0",    32'(j_out), 32'h1);
        check("up_busy0", 32'(busy),  32'd1);
        @(posedge clk); #1;
        check("up_q1",    32'(q),     32'hF);
        check("up_j1",    32'(j_out), 32'hF);
        check("up_busy1", 32'(busy),  32'd1);
        check("up_done1", 32'(done),  32'd0);
        @(posedge clk); #1;
        check("up_q2",    32'(q),     32'h0);
        check("up_busy2", 32'(busy),  32'd1);
        @(posedge clk); #1;
        check("up_q3",    32'(q),     32'h1);
        check("up_busy3", 32'(busy),  32'd1);
        check("up_done3", 32'(done),  32'd1);
        @(posedge clk); #1;
        check("up_busy4", 32'(busy),      32'd0);
        check("up_rdy4",  32'(cmd_ready), 32'd1);

        // Count down 1 from 0000 wraps to 1111
        single("ld_0", 3'b001, 4'b0000, 4'b0000, 4'b1111, 4'b0000);
        send(3'b110, 4'b0000, 4'd1);
        check("dn_j", 32'(j_out), 32'hF);
        check("dn_k", 32'(k_out), 32'hF);
        @(posedge clk); #1;
        check("dn_q",    32'(q),    32'hF);
        check("dn_done", 32'(done), 32'd1);
        @(posedge clk); #1;
        check("dn_rdy", 32'(cmd_ready), 32'd1);

        // Count 0 on a repeat op: one idle EXEC cycle, done still pulses
        single("ld_1", 3'b001, 4'b0001, 4'b0001, 4'b1110, 4'b0001);
        send(3'b101, 4'b0000, 4'd0);
        check("z_busy", 32'(busy),  32'd1);
        check("z_j",    32'(j_out), 32'h0);
        check("z_k",    32'(k_out), 32'h0);
        @(posedge clk); #1;
        check("z_q",    32'(q),     32'h1);
        check("z_done", 32'(done),  32'd1);
        @(posedge clk); #1;
        check("z_rdy",  32'(cmd_ready), 32'd1);
        check("z_q2",   32'(q),         32'h1);

        // Rotate left twice from 1001
        single("ld_9", 3'b001, 4'b1001, 4'b1001, 4'b0110, 4'b1001);
        send(3'b111, 4'b0000, 4'd2);
        check("rot_j", 32'(j_out), 32'h3);
        check("rot_k", 32'(k_out), 32'hC);
        @(posedge clk); #1;
        check("rot_q1",    32'(q),    32'h3);
        check("rot_done1", 32'(done), 32'd0);
        @(posedge clk); #1;
        check("rot_q2",    32'(q),    32'h6);
        check("rot_done2", 32'(done), 32'd1);
        @(posedge clk); #1;

        // Reset in the middle of a long count aborts without done
        single("ld_r", 3'b001, 4'b0000, 4'b0000, 4'b1111, 4'b0000);
        send(3'b101, 4'b0000, 4'd10);
        repeat (3) @(posedge clk);
        #1;
        check("ab_q_pre", 32'(q), 32'h3);
        #2;
        rst = 1'b1;
        #1;
        check("ab_q",    32'(q),         32'h0);
        check("ab_busy", 32'(busy),      32'd0);
        check("ab_done", 32'(done),      32'd0);
        check("ab_j",    32'(j_out),     32'h0);
        check("ab_rdy",  32'(cmd_ready), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        done_seen = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (done) done_seen++;
        end
        check("ab_nodone", 32'(done_seen), 32'd0);
        check("ab_rdy2",   32'(cmd_ready), 32'd1);
        check("ab_q2",     32'(q),         32'h0);

        // cmd_valid held through DONE: second toggle only on the IDLE edge
        @(negedge clk);
        cmd_op    = 3'b100;
        cmd_arg   = 4'b1111;
        cmd_count = 4'd0;
        cmd_valid = 1'b1;
        @(posedge clk); #1;
        check("hv_busy0", 32'(busy), 32'd1);
        @(posedge clk); #1;
        check("hv_q1",    32'(q),    32'hF);
        check("hv_done1", 32'(done), 32'd1);
        @(posedge clk); #1;
        check("hv_busy2", 32'(busy),      32'd0);
        check("hv_rdy2",  32'(cmd_ready), 32'd1);
        check("hv_q2",    32'(q),         32'hF);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        check("hv_busy3", 32'(busy), 32'd1);
        @(posedge clk); #1;
        check("hv_q4",    32'(q),    32'h0);
        check("hv_done4", 32'(done), 32'd1);
        @(posedge clk); #1;
        check("hv_rdy5",  32'(cmd_ready), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule

// File: doc/jk_bank_controller.md
# jk_bank_controller

Command-driven sequencer for a WIDTH-bit bank of JK flip-flops. Each accepted command is translated, per cycle, into the J/K drive for every cell, implementing load, set, clear, toggle, multi-step counting and rotation. It sits between a simple valid/ready command source (switch/button logic or a test driver) and the JK register bank. The JK cells are instantiated inside the block.

## Interface
- WIDTH, 4, number of JK cells in the bank (2..8)
- clk  input  1  single clock; all state changes on rising edge
- rst  input  1  asynchronous, active-high reset
- cmd_valid  input  1  command present
- cmd_ready  output  1  high only in IDLE; command accepted on edge where cmd_valid & cmd_ready
- cmd_op  input  3  opcode (see Operation)
- cmd_arg  input  WIDTH  data/mask operand
- cmd_count  input  4  step count for repeat ops (101–111)
- q  output  WIDTH  bank contents (JK cell outputs)
- j_out  output  WIDTH  J drive applied at next edge; 0 outside EXEC
- k_out  output  WIDTH  K drive applied at next edge; 0 outside EXEC
- busy  output  1  high in EXEC and DONE
- done  output  1  one-cycle pulse in DONE state

## Operation
- JK cell rule, every edge, per bit: q_next = (j & ~q) | (~k & q); j=k=0 holds.
- FSM states: IDLE, EXEC, DONE.
  - IDLE -> EXEC on accept; op/arg/count are latched, and the step counter is loaded with count (repeat ops) or 1 (single ops).
  - EXEC: drives J/K each cycle and decrements steps. Moves to DONE on the cycle where steps reaches 1, or immediately if steps = 0.
  - DONE -> IDLE unconditionally.
- Opcodes and J/K drive (a = latched arg):
  - 000 NOP: j=0, k=0, 1 step.
  - 001 LOAD: j=a, k=~a, 1 step.
  - 010 CLEAR: j=0, k=a, 1 step. Only masked bits are cleared.
  - 011 SET: j=a, k=0, 1 step.
  - 100 TOGGLE: j=k=a, 1 step.
  - 101 COUNT UP: j=k=t, with t[0]=1 and t[i]=&q[i-1:0]. Steps = count.
  - 110 COUNT DOWN: j=k=t, with t[0]=1 and t[i]=&~q[i-1:0]. Steps = count.
  - 111 ROTATE LEFT: j=r, k=~r, with r={q[WIDTH-2:0],q[WIDTH-1]}. Steps = count.
- count = 0 on a repeat op:
  - one EXEC cycle with j=k=0, so q is unchanged;
  - done still pulses.
- Arithmetic wraps modulo 2^WIDTH: all-ones up -> 0, and 0 down -> all-ones.
- cmd_* inputs are ignored outside the accept edge. Changing them mid-operation has no effect.
- A cmd_valid held high through DONE is not accepted until the first IDLE edge.

## Timing
- Reset values:
  - q=0 and state=IDLE;
  - cmd_ready=1 (ignored while rst high);
  - busy=0, done=0, j_out=k_out=0.
- Reset asserted mid-operation aborts immediately: q=0, IDLE, no done pulse.
- With accept at edge E0 and N steps (N ≥ 1):
  - q updates at edges E1..EN;
  - done is high for the cycle between EN and EN+1;
  - cmd_ready is high again after EN+1.
- Command-to-command throughput is N+2 cycles.
- With N = 0 (repeat op, count 0): EXEC for one cycle, done after E1, ready after E2.
- j_out/k_out are combinational from state, latched op and q. They are valid for the whole EXEC cycle before the edge at which they take effect.

## Test plan
- Reset, then LOAD a=1010 -> q=1010 at E1; done pulses one cycle; cmd_ready returns 2 cycles after accept.
- From q=1010:
  - SET a=0101 -> q=1111;
  - CLEAR a=0011 -> q=1100;
  - TOGGLE a=1111 -> q=0011.
- From q=1110, COUNT UP count=3 -> q=1111, 0000, 0001 on consecutive edges; busy high for 4 cycles.
- From q=0000, COUNT DOWN count=1 -> q=1111.
- With q=0001, COUNT UP count=0 -> q stays 0001; done still pulses.
- From q=1001, ROTATE LEFT count=2 -> 0011, then 0110.
- Assert rst during EXEC of a COUNT UP count=10 -> q=0 immediately, no done, cmd_ready high after release.
- A cmd_valid held through DONE is accepted only in IDLE.
